// File: rtl/acc_drain.sv
`timescale 1ns/1ps
// acc_drain: read-side controller for the accumulator.
// Reads one accumulator address per beat, undoes the diagonal skew of the
// returned lanes and streams row-aligned vectors over valid/ready.
//
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   start_i                one-cycle drain request (sampled in IDLE only)
//   base_addr_i            first accumulator row to drain
//   num_rows_i             rows to drain (0 = no-op, only done_o pulses)
//   busy_o, done_o         drain in progress / one-cycle completion pulse
//   acc_rd_en_o            accumulator read enable
//   acc_addr_rd_o          accumulator read address
//   acc_data_i             read data, one cycle after acc_rd_en_o
//   out_valid_o/ready_i    row stream handshake
//   out_data_o             row vector, lane j = column j
//   out_row_addr_o         accumulator row of out_data_o
//   out_last_o             final row of the drain
module acc_drain #(
    parameter int unsigned LANES      = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned ADDR_W     = 7,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_i,
    input  logic [ADDR_W-1:0]         base_addr_i,
    input  logic [ADDR_W:0]           num_rows_i,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      acc_rd_en_o,
    output logic [ADDR_W-1:0]         acc_addr_rd_o,
    input  logic [LANES*DATA_W-1:0]   acc_data_i,
    output logic                      out_valid_o,
    input  logic                      out_ready_i,
    output logic [LANES*DATA_W-1:0]   out_data_o,
    output logic [ADDR_W-1:0]         out_row_addr_o,
    output logic                      out_last_o
);

    localparam int unsigned VEC_W  = LANES * DATA_W;
    localparam int unsigned SKEW   = LANES - 1;
    localparam int unsigned BEAT_W = $clog2((2 ** ADDR_W) + LANES + 1);
    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OCC_W  = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_FLUSH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   base_q, base_d;
    logic [ADDR_W:0]     n_q, n_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                done_q, done_d;

    // Tag of the beat whose data is on acc_data_i this cycle.
    logic                tag_q;
    logic                tag_push_q;
    logic                tag_last_q;
    logic [ADDR_W-1:0]   tag_row_q;

    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [VEC_W-1:0]    mem_data_q [FIFO_DEPTH];
    logic [ADDR_W-1:0]   mem_addr_q [FIFO_DEPTH];
    logic                mem_last_q [FIFO_DEPTH];

    logic                push_c, pop_c, issue_c, head_last_c;
    logic [BEAT_W-1:0]   last_beat_c;
    logic [ADDR_W-1:0]   issue_addr_c;
    logic [OCC_W-1:0]    occ_next_c;
    logic [VEC_W-1:0]    row_c;

    assign push_c       = tag_q & tag_push_q;
    assign pop_c        = (cnt_q != '0) & out_ready_i;
    assign head_last_c  = mem_last_q[rd_ptr_q];
    assign last_beat_c  = BEAT_W'(n_q) + BEAT_W'(SKEW - 1);
    assign issue_addr_c = base_q + ADDR_W'(beat_q);
    assign occ_next_c   = OCC_W'(cnt_q) + OCC_W'(push_c) - OCC_W'(pop_c);

    // Next-state, beat issue and read-port drive.
    always_comb begin
        state_d       = state_q;
        base_d        = base_q;
        n_d           = n_q;
        beat_d        = beat_q;
        addr_d        = addr_q;
        done_d        = 1'b0;
        issue_c       = 1'b0;
        acc_rd_en_o   = 1'b0;
        acc_addr_rd_o = addr_q;
        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (num_rows_i != '0) begin
                        base_d  = base_addr_i;
                        n_d     = num_rows_i;
                        beat_d  = '0;
                        state_d = S_ISSUE;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                // Prologue beats never push; later beats need a guaranteed slot.
                issue_c = (beat_q < BEAT_W'(SKEW)) || (occ_next_c < OCC_W'(FIFO_DEPTH));
                if (issue_c) begin
                    acc_rd_en_o   = 1'b1;
                    acc_addr_rd_o = issue_addr_c;
                    addr_d        = issue_addr_c;
                    beat_d        = beat_q + BEAT_W'(1);
                    if (beat_q == last_beat_c) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (!tag_q && pop_c && head_last_c) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Control state and in-flight tag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            base_q     <= '0;
            n_q        <= '0;
            beat_q     <= '0;
            addr_q     <= '0;
            done_q     <= 1'b0;
            tag_q      <= 1'b0;
            tag_push_q <= 1'b0;
            tag_last_q <= 1'b0;
            tag_row_q  <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            n_q        <= n_d;
            beat_q     <= beat_d;
            addr_q     <= addr_d;
            done_q     <= done_d;
            tag_q      <= issue_c;
            tag_push_q <= issue_c && (beat_q >= BEAT_W'(SKEW));
            tag_last_q <= issue_c && (beat_q == last_beat_c);
            tag_row_q  <= issue_addr_c - ADDR_W'(SKEW);
        end
    end

    // Deskew: lane j is delayed by (LANES-1-j) returned beats so all lanes line up.
    for (genvar j = 0; j < LANES; j++) begin : g_lane
        localparam int unsigned DLY = LANES - 1 - j;
        if (DLY == 0) begin : g_direct
            assign row_c[j*DATA_W +: DATA_W] = acc_data_i[j*DATA_W +: DATA_W];
        end else begin : g_sr
            logic [DATA_W-1:0] sr_q [DLY];
            always_ff @(posedge clk_i or posedge rst_i) begin
                if (rst_i) begin
                    for (int k = 0; k < DLY; k++) sr_q[k] <= '0;
                end else if (tag_q) begin
                    sr_q[0] <= acc_data_i[j*DATA_W +: DATA_W];
                    for (int k = 1; k < DLY; k++) sr_q[k] <= sr_q[k-1];
                end
            end
            assign row_c[j*DATA_W +: DATA_W] = sr_q[DLY-1];
        end
    end

    // Output FIFO; the issue gate guarantees it never overflows.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_data_q[i] <= '0;
                mem_addr_q[i] <= '0;
                mem_last_q[i] <= 1'b0;
            end
        end else begin
            if (push_c) begin
                mem_data_q[wr_ptr_q] <= row_c;
                mem_addr_q[wr_ptr_q] <= tag_row_q;
                mem_last_q[wr_ptr_q] <= tag_last_q;
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            cnt_q <= cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    assign busy_o         = (state_q != S_IDLE);
    assign done_o         = done_q;
    assign out_valid_o    = (cnt_q != '0);
    assign out_data_o     = mem_data_q[rd_ptr_q];
    assign out_row_addr_o = mem_addr_q[rd_ptr_q];
    assign out_last_o     = out_valid_o & head_last_c;

endmodule

// File: tb/tb_acc_drain.sv
`timescale 1ns/1ps
module tb_acc_drain;

    localparam int unsigned LANES  = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 7;
    localparam int unsigned VEC_W  = LANES * DATA_W;

    logic                clk;
    logic                rst;
    logic                start;
    logic [ADDR_W-1:0]   base_addr;
    logic [ADDR_W:0]     num_rows;
    logic                busy, done, rd_en;
    logic [ADDR_W-1:0]   rd_addr;
    logic [VEC_W-1:0]    acc_data;
    logic                out_valid, out_ready, out_last;
    logic [VEC_W-1:0]    out_data;
    logic [ADDR_W-1:0]   out_row;

    int checks = 0;
    int errors = 0;

    acc_drain #(.LANES(LANES), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(2)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .base_addr_i(base_addr),
        .num_rows_i(num_rows), .busy_o(busy), .done_o(done), .acc_rd_en_o(rd_en),
        .acc_addr_rd_o(rd_addr), .acc_data_i(acc_data), .out_valid_o(out_valid),
        .out_ready_i(out_ready), .out_data_o(out_data), .out_row_addr_o(out_row),
        .out_last_o(out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected row contents: row r, lane j = r*256 + j.
    function automatic logic [VEC_W-1:0] exp_row(input int r);
        logic [VEC_W-1:0] v;
        for (int j = 0; j < LANES; j++) v[j*DATA_W +: DATA_W] = DATA_W'(((r % 128) * 256) + j);
        return v;
    endfunction

    // Accumulator model: lane j of address a returns row (a - j) mod 128.
    function automatic logic [VEC_W-1:0] acc_read(input logic [ADDR_W-1:0] a);
        logic [VEC_W-1:0] v;
        logic [ADDR_W-1:0] r;
        for (int j = 0; j < LANES; j++) begin
            r = a - ADDR_W'(j);
            v[j*DATA_W +: DATA_W] = DATA_W'((int'(r) * 256) + j);
        end
        return v;
    endfunction

    always @(posedge clk) begin
        if (rd_en === 1'b1) acc_data <= acc_read(rd_addr);
        else                acc_data <= '0;
    end

    // Observations of one drain run.
    logic [ADDR_W-1:0] rd_log[$];
    logic [ADDR_W-1:0] pop_addr[$];
    logic [VEC_W-1:0]  pop_data[$];
    logic              pop_last[$];
    int                pop_cyc[$];
    int rd_cnt, first_valid, done_cnt, done_cyc, max_occ, occ_err, unstable, rd_gaps, busy_err;
    bit timed_out;

    // Drives one drain and records what the DUT does, cycle by cycle.
    // mode 0: ready always high; mode 1: ready one cycle in four.
    task automatic run_drain(input int base, input int n, input int mode,
                             input int restart_at, input int abort_pops, input int max_cycles);
        int occ, beat, h1, h2, flag;
        bit hold, done_seen;
        logic [VEC_W-1:0] hold_data;
        logic [ADDR_W-1:0] hold_addr;
        rd_log.delete(); pop_addr.delete(); pop_data.delete(); pop_last.delete(); pop_cyc.delete();
        rd_cnt = 0; first_valid = -1; done_cnt = 0; done_cyc = -1; max_occ = 0;
        occ_err = 0; unstable = 0; rd_gaps = 0; busy_err = 0;
        occ = 0; beat = 0; h1 = 0; h2 = 0; hold = 0; done_seen = 0;
        hold_data = '0; hold_addr = '0;
        @(negedge clk);
        start = 1'b1; base_addr = ADDR_W'(base); num_rows = (ADDR_W+1)'(n);
        @(negedge clk);
        start = 1'b0;
        timed_out = 1'b1;
        for (int c = 0; c < max_cycles; c++) begin
            out_ready = (mode == 0) ? 1'b1 : ((c % 4) == 0);
            if (c == restart_at) begin
                start = 1'b1; base_addr = 7'd77; num_rows = 8'd2;
            end else begin
                start = 1'b0;
            end
            #1;
            occ += h2;
            if (out_valid !== (occ > 0)) occ_err++;
            if (occ > max_occ) max_occ = occ;
            if (hold && (out_data !== hold_data || out_row !== hold_addr)) unstable++;
            flag = 0;
            if (rd_en === 1'b1) begin
                rd_log.push_back(rd_addr);
                rd_cnt++;
                flag = (beat >= 31) ? 1 : 0;
                beat++;
            end else if (beat > 0 && beat < n + 31) begin
                rd_gaps++;
            end
            if (out_valid === 1'b1 && first_valid < 0) first_valid = c;
            if (done === 1'b1) begin
                done_cnt++;
                if (!done_seen) done_cyc = c;
                done_seen = 1'b1;
            end
            if (busy !== ((n > 0) && !done_seen)) busy_err++;
            hold = 1'b0;
            if (out_valid === 1'b1 && out_ready) begin
                pop_addr.push_back(out_row); pop_data.push_back(out_data);
                pop_last.push_back(out_last); pop_cyc.push_back(c);
                occ--;
            end else if (out_valid === 1'b1) begin
                hold = 1'b1; hold_data = out_data; hold_addr = out_row;
            end
            h2 = h1; h1 = flag;
            if (done_seen && c >= done_cyc + 3) begin timed_out = 1'b0; break; end
            if (abort_pops > 0 && pop_addr.size() == abort_pops) begin timed_out = 1'b0; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; base_addr = '0; num_rows = '0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, rd_en, out_valid, out_last} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, rd_en, out_valid, out_last});
        end
        checks++;
        if (out_data !== '0 || out_row !== '0 || rd_addr !== '0) begin
            errors++; $display("FAIL reset_data: row %0d addr %0d expected 0", out_row, rd_addr);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, done, rd_en, out_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_release: got %b expected 0000", {busy, done, rd_en, out_valid});
        end
    endtask

    task automatic test_basic();
        int bad;
        run_drain(0, 4, 0, -1, 0, 200);
        checks++;
        if (timed_out) begin errors++; $display("FAIL basic_timeout: got no done expected done"); end
        checks++;
        if (rd_cnt != 35) begin errors++; $display("FAIL basic_rd_cnt: got %0d expected 35", rd_cnt); end
        bad = 0;
        foreach (rd_log[i]) if (rd_log[i] !== ADDR_W'(i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL basic_rd_addr: got %0d bad addresses expected 0", bad); end
        checks++;
        if (first_valid != 33) begin errors++; $display("FAIL basic_latency: got %0d expected 33", first_valid); end
        checks++;
        if (pop_addr.size() != 4) begin errors++; $display("FAIL basic_rows: got %0d expected 4", pop_addr.size()); end
        for (int i = 0; i < pop_addr.size() && i < 4; i++) begin
            checks++;
            if (pop_addr[i] !== ADDR_W'(i) || pop_data[i] !== exp_row(i) || pop_cyc[i] != 33 + i
                || pop_last[i] !== (i == 3)) begin
                errors++;
                $display("FAIL basic_row%0d: got addr %0d cyc %0d last %b lane0 %h expected addr %0d cyc %0d",
                         i, pop_addr[i], pop_cyc[i], pop_last[i], pop_data[i][31:0], i, 33 + i);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 37) begin
            errors++; $display("FAIL basic_done: got %0d pulses at %0d expected 1 at 37", done_cnt, done_cyc);
        end
        checks++;
        if (busy_err != 0) begin errors++; $display("FAIL basic_busy: got %0d bad cycles expected 0", busy_err); end
    endtask

    task automatic test_wrap();
        int bad;
        run_drain(124, 8, 0, -1, 0, 200);
        checks++;
        if (timed_out || rd_cnt != 39) begin
            errors++; $display("FAIL wrap_rd_cnt: got %0d (timeout %0d) expected 39", rd_cnt, timed_out);
        end
        bad = 0;
        foreach (rd_log[i]) if (rd_log[i] !== ADDR_W'(124 + i)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL wrap_rd_addr: got %0d bad addresses expected 0", bad); end
        checks++;
        if (pop_addr.size() != 8) begin errors++; $display("FAIL wrap_rows: got %0d expected 8", pop_addr.size()); end
        for (int i = 0; i < pop_addr.size() && i < 8; i++) begin
            checks++;
            if (pop_addr[i] !== ADDR_W'(124 + i) || pop_data[i] !== exp_row((124 + i) % 128)
                || pop_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL wrap_row%0d: got addr %0d lane0 %h expected addr %0d", i, pop_addr[i],
                         pop_data[i][31:0], (124 + i) % 128);
            end
        end
        checks++;
        if (done_cnt != 1 || done_cyc != 41) begin
            errors++; $display("FAIL wrap_done: got %0d pulses at %0d expected 1 at 41", done_cnt, done_cyc);
        end
    endtask

    task automatic test_back_pressure();
        run_drain(20, 10, 1, -1, 0, 400);
        checks++;
        if (timed_out || rd_cnt != 41) begin
            errors++; $display("FAIL bp_rd_cnt: got %0d (timeout %0d) expected 41", rd_cnt, timed_out);
        end
        checks++;
        if (rd_gaps == 0) begin errors++; $display("FAIL bp_gaps: got %0d stall cycles expected >0", rd_gaps); end
        checks++;
        if (max_occ > 2 || occ_err != 0) begin
            errors++; $display("FAIL bp_occupancy: got max %0d, %0d valid errors expected <=2, 0", max_occ, occ_err);
        end
        checks++;
        if (unstable != 0) begin errors++; $display("FAIL bp_stable: got %0d changes expected 0", unstable); end
        checks++;
        if (pop_addr.size() != 10) begin errors++; $display("FAIL bp_rows: got %0d expected 10", pop_addr.size()); end
        for (int i = 0; i < pop_addr.size() && i < 10; i++) begin
            checks++;
            if (pop_addr[i] !== ADDR_W'(20 + i) || pop_data[i] !== exp_row(20 + i) || pop_last[i] !== (i == 9)) begin
                errors++;
                $display("FAIL bp_row%0d: got addr %0d lane0 %h expected addr %0d", i, pop_addr[i],
                         pop_data[i][31:0], 20 + i);
            end
        end
        checks++;
        if (done_cnt != 1 || pop_cyc.size() == 0 || done_cyc != pop_cyc[pop_cyc.size()-1] + 1) begin
            errors++; $display("FAIL bp_done: got %0d pulses at %0d expected 1 after last pop", done_cnt, done_cyc);
        end
    endtask

    task automatic test_full();
        int bad;
        run_drain(0, 128, 0, -1, 0, 400);
        checks++;
        if (timed_out || rd_cnt != 159) begin
            errors++; $display("FAIL full_rd_cnt: got %0d (timeout %0d) expected 159", rd_cnt, timed_out);
        end
        checks++;
        if (pop_addr.size() != 128) begin errors++; $display("FAIL full_rows: got %0d expected 128", pop_addr.size()); end
        bad = 0;
        foreach (pop_addr[i])
            if (pop_addr[i] !== ADDR_W'(i) || pop_data[i] !== exp_row(i) || pop_cyc[i] != 33 + i
                || pop_last[i] !== (i == 127)) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL full_row_content: got %0d bad rows expected 0", bad); end
        checks++;
        if (done_cnt != 1 || done_cyc != 161) begin
            errors++; $display("FAIL full_done: got %0d pulses at %0d expected 1 at 161", done_cnt, done_cyc);
        end
    endtask

    task automatic test_noop_and_restart();
        run_drain(9, 0, 0, -1, 0, 20);
        checks++;
        if (timed_out || rd_cnt != 0 || done_cnt != 1 || done_cyc != 0) begin
            errors++;
            $display("FAIL noop: got rd %0d done %0d at %0d expected rd 0 done 1 at 0", rd_cnt, done_cnt, done_cyc);
        end
        checks++;
        if (busy_err != 0) begin errors++; $display("FAIL noop_busy: got %0d busy cycles expected 0", busy_err); end
        run_drain(10, 3, 0, 5, 0, 200);
        checks++;
        if (timed_out || rd_cnt != 34 || done_cnt != 1) begin
            errors++; $display("FAIL restart_ignored: got rd %0d done %0d expected rd 34 done 1", rd_cnt, done_cnt);
        end
        checks++;
        if (pop_addr.size() != 3 || pop_addr[0] !== 7'd10 || pop_addr[2] !== 7'd12 || pop_data[1] !== exp_row(11)) begin
            errors++; $display("FAIL restart_rows: got %0d rows expected rows 10..12", pop_addr.size());
        end
    endtask

    task automatic test_reset_mid();
        int dn;
        run_drain(0, 8, 0, -1, 3, 200);
        checks++;
        if (timed_out || pop_addr.size() != 3) begin
            errors++; $display("FAIL rstmid_prefix: got %0d rows expected 3", pop_addr.size());
        end
        checks++;
        if (busy !== 1'b1 || out_valid !== 1'b1) begin
            errors++; $display("FAIL rstmid_active: got busy %b valid %b expected 1 1", busy, out_valid);
        end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++;
        if ({busy, done, rd_en, out_valid, out_last} !== 5'b0 || out_data !== '0 || out_row !== '0 || rd_addr !== '0) begin
            errors++;
            $display("FAIL rstmid_async: got ctrl %b row %0d addr %0d expected all 0",
                     {busy, done, rd_en, out_valid, out_last}, out_row, rd_addr);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        dn = 0;
        repeat (6) begin
            @(negedge clk);
            if (done === 1'b1 || out_valid === 1'b1) dn++;
        end
        checks++;
        if (dn != 0) begin errors++; $display("FAIL rstmid_quiet: got %0d active cycles expected 0", dn); end
        run_drain(5, 3, 0, -1, 0, 200);
        checks++;
        if (timed_out || rd_cnt != 34 || done_cnt != 1 || first_valid != 33) begin
            errors++;
            $display("FAIL rstmid_redrain: got rd %0d done %0d first %0d expected 34 1 33", rd_cnt, done_cnt, first_valid);
        end
        checks++;
        if (pop_addr.size() != 3) begin errors++; $display("FAIL rstmid_rows: got %0d expected 3", pop_addr.size()); end
        for (int i = 0; i < pop_addr.size() && i < 3; i++) begin
            checks++;
            if (pop_addr[i] !== ADDR_W'(5 + i) || pop_data[i] !== exp_row(5 + i) || pop_last[i] !== (i == 2)) begin
                errors++;
                $display("FAIL rstmid_row%0d: got addr %0d lane0 %h expected addr %0d", i, pop_addr[i],
                         pop_data[i][31:0], 5 + i);
            end
        end
    endtask

    initial begin
        acc_data = '0;
        test_reset();
        test_basic();
        test_wrap();
        test_back_pressure();
        test_full();
        test_noop_and_restart();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/acc_drain.md
Name: acc_drain

Overview:
- Read-side controller for the accumulator.
- Drives the accumulator read port (rd_en, addr_rd) with one address per beat.
- Re-aligns the diagonally skewed 32-lane read data back into row-aligned 32x32-bit vectors.
- Streams those vectors to the activation / unified-buffer path over a valid/ready interface with back-pressure.
- Counterpart of the systolic-array write path, which fills the accumulator diagonally.

Parameters:
- LANES, 32: vector width in lanes. Equals the accumulator column count.
- DATA_W, 32: bits per lane.
- ADDR_W, 7: accumulator row address width (128 rows).
- FIFO_DEPTH, 2: output FIFO entries. Minimum 2.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  one-cycle drain request; sampled only in IDLE.
- base_addr_i  in  ADDR_W  first accumulator row to drain.
- num_rows_i  in  ADDR_W+1  rows to drain, 1..128; 0 is a no-op.
- busy_o  out  1  high from start accept until done_o.
- done_o  out  1  one-cycle pulse after the last row handshakes (or for a no-op).
- acc_rd_en_o  out  1  accumulator read enable (port1).
- acc_addr_rd_o  out  ADDR_W  accumulator read address.
- acc_data_i  in  LANES x DATA_W  accumulator read data; valid 1 cycle after acc_rd_en_o.
- out_valid_o  out  1  out_data_o holds a complete row.
- out_ready_i  in  1  consumer accepts the row when high together with valid.
- out_data_o  out  LANES x DATA_W  row vector; lane j = column j.
- out_row_addr_o  out  ADDR_W  accumulator row of out_data_o.
- out_last_o  out  1  marks the final row of the drain.

Behaviour:
- Reset (async, rst_i=1): state IDLE; all counters, FIFO, deskew lanes and in-flight tag cleared. busy_o, done_o, acc_rd_en_o, out_valid_o, out_last_o = 0. acc_addr_rd_o, out_row_addr_o, out_data_o = 0. Reset mid-drain discards everything; no done_o.
- Top level holds the accumulator add input low whenever busy_o=1; the drain relies on this.
- Accumulator read semantics: with addr_rd=a, lane j returns row (a-j) mod 128, one cycle later. When rd_en=0, the returned data is zero and ignored.
- States: IDLE -> ISSUE -> FLUSH -> IDLE.
  - IDLE: on start_i with num_rows_i>0, latch base address and N, clear beat counter b, go to ISSUE, busy_o=1.
  - IDLE: on start_i with num_rows_i=0, pulse done_o next cycle, stay IDLE, busy_o stays 0.
  - ISSUE: a beat issues when the gate below allows it. An issued beat sets acc_rd_en_o=1, acc_addr_rd_o=(base+b) mod 128, increments b and sets the in-flight tag for the next cycle. After beat b=N+30 issues, go to FLUSH.
  - FLUSH: wait until no beat is in flight and the FIFO is empty. On the final pop, pulse done_o for one cycle the following cycle, deassert busy_o in that same cycle, return to IDLE.
  - start_i while busy is ignored.
- Deskew: on each returned (tagged) beat, lane j passes through a (31-j)-stage shift register that advances only on tagged beats. Lane 31 has zero delay. On the returned beat of index b>=31, all lanes hold row base+(b-31). That row plus its address (mod 128) and last flag (b=N+30) are pushed into the FIFO in the same cycle.
- Lanes referring to rows outside base..base+N-1 (including negative or wrapped indices for b<31) are don't-care and never reach the output.
- Issue gate: beats with b<31 always issue. For b>=31, issue at cycle t only if occupancy(t+1) = occ + push_t - pop_t < FIFO_DEPTH. This guarantees the returned row always has a slot. A stalled cycle drives acc_rd_en_o=0 and holds acc_addr_rd_o.
- Total issued beats = N+31. Best-case latency from start accept to first out_valid_o = 33 cycles.
- Throughput with out_ready_i held high: one row per cycle.
- Output: out_valid_o = FIFO non-empty; data, address and last come from the FIFO head. Pop on valid & ready. Head stays stable while valid & !ready.
- Address arithmetic wraps mod 128; base=120, N=16 drains rows 120..127, 0..7.

Test Plan:
- Preload row r lane j = r*256+j for all rows. start base=0, N=4, ready=1 -> 35 rd_en pulses at addr 0..34; rows 0..3 out on consecutive cycles, first out_valid_o 33 cycles after accept; lane j = r*256+j; out_last_o on row 3; done_o 1 cycle after.
- Wrap: base=124, N=8 -> out_row_addr_o sequence 124..127, 0..3 with correct data.
- Back-pressure: N=10, out_ready_i toggling 1 cycle on / 3 off -> no row lost or duplicated; rd_en gaps observed; FIFO occupancy never exceeds 2.
- N=128, base=0, ready=1 -> 159 beats, 128 rows in order, single done_o.
- start with num_rows_i=0 -> no rd_en, done_o pulse, busy_o stays 0. A second start while busy -> ignored.
- Assert rst_i asynchronously mid-drain (after row 2) -> outputs 0 immediately. A subsequent drain of base=5, N=3 is clean with no stale rows.
